sram_like_arbiter: RTL and testbench



---
 rtl/sram_like_arbiter_pkg.sv | 27 ++
 rtl/sram_like_arbiter_if.sv | 27 ++
 rtl/sram_like_arbiter_pick.sv | 39 +++
 rtl/sram_like_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_like_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like port arbiter.
//   state_e  : transaction phase (IDLE / ADDR / DATA)
//   owner_e  : which master currently owns the memory port
//   SZ_*     : sram-like size encodings
//   starve_cnt_w() : width of the starvation counter, never below 1 bit
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   function automatic int starve_cnt_w(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like bus: request fields driven by the master, handshakes and
// read data driven by the slave.
//   req/wr/size/addr/wdata : request (master -> slave)
//   addr_ok/data_ok/rdata  : address accept, completion, read data (slave -> master)
interface sram_like_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          wr;
   logic [1:0]    size;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          addr_ok;
   logic          data_ok;
   logic [DW-1:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_arbiter_pick.sv
// Grant decision for the sram-like arbiter (combinational only).
//   inst_req, data_req : pending requests
//   starve_cnt         : consecutive data grants while inst waited (default build)
//   last_grant         : previous grant (SRAM_ARB_RR_EN build)
//   owner              : master to grant; OWN_DATA when nothing is pending
// Macro SRAM_ARB_RR_EN selects strict round-robin instead of data priority
// with a starvation limit.
module sram_arb_pick
   import sram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CW           = starve_cnt_w(STARVE_LIMIT)
) (
   input  logic          inst_req,
   input  logic          data_req,
`ifdef SRAM_ARB_RR_EN
   input  owner_e        last_grant,
`else
   input  logic [CW-1:0] starve_cnt,
`endif
   output owner_e        owner
);

   always_comb begin
      owner = OWN_DATA;
      if (inst_req && !data_req) begin
         owner = OWN_INST;
      end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
         owner = (last_grant == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
         if ((STARVE_LIMIT != 0) && (starve_cnt == CW'(STARVE_LIMIT))) begin
            owner = OWN_INST;
         end
`endif
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the instruction-fetch and the
// data-access masters, one transaction outstanding at a time.
//   clk, rst : clock, asynchronous active-high reset
//   inst     : instruction master port (slave side of the bus)
//   data     : data master port (slave side of the bus)
//   mem      : downstream memory port (master side of the bus)
//   busy     : a transaction is in its address or data phase
// Macro SRAM_ARB_RR_EN: round-robin arbitration; when undefined, data wins
// with a starvation counter that forces inst after STARVE_LIMIT data grants.
//
// state | meaning
// IDLE  | no transaction; pending requests are arbitrated and the owner latched
// ADDR  | owner's request presented on mem, waiting for mem.addr_ok
// DATA  | address accepted, waiting for mem.data_ok
module sram_like_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   sram_like_arbiter_if.slave  inst,
   sram_like_arbiter_if.slave  data,
   sram_like_arbiter_if.master mem,
   output logic               busy
);

   localparam int CW = starve_cnt_w(STARVE_LIMIT);

   state_e        state;
   owner_e        owner;
   owner_e        pick;
   logic [DW-1:0] inst_rdata_q;
   logic [DW-1:0] data_rdata_q;
   logic          any_req;
   logic          own_req;
   logic          acc;
   logic          fin;

`ifdef SRAM_ARB_RR_EN
   owner_e        last_grant;
`else
   logic [CW-1:0] starve_cnt;
`endif

   assign any_req = inst.req | data.req;
   assign own_req = (owner == OWN_INST) ? inst.req : data.req;
   // mem.req is only raised in ADDR, so an addr_ok outside that window
   // (or after the owner withdrew) is ignored here.
   assign acc     = (state == ADDR) && own_req && mem.addr_ok;
   assign fin     = (state == DATA) && mem.data_ok;
   assign busy    = (state != IDLE);

   sram_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CW           (CW)
   ) u_pick (
      .inst_req   (inst.req),
      .data_req   (data.req),
`ifdef SRAM_ARB_RR_EN
      .last_grant (last_grant),
`else
      .starve_cnt (starve_cnt),
`endif
      .owner      (pick)
   );

   always_comb begin
      mem.req   = 1'b0;
      mem.wr    = 1'b0;
      mem.size  = 2'b00;
      mem.addr  = {AW{1'b0}};
      mem.wdata = {DW{1'b0}};
      if (state == ADDR) begin
         mem.req = own_req;
         if (owner == OWN_INST) begin
            mem.wr    = inst.wr;
            mem.size  = inst.size;
            mem.addr  = inst.addr;
            mem.wdata = inst.wdata;
         end else begin
            mem.wr    = data.wr;
            mem.size  = data.size;
            mem.addr  = data.addr;
            mem.wdata = data.wdata;
         end
      end
   end

   assign inst.addr_ok = acc && (owner == OWN_INST);
   assign data.addr_ok = acc && (owner == OWN_DATA);
   assign inst.data_ok = fin && (owner == OWN_INST);
   assign data.data_ok = fin && (owner == OWN_DATA);

   // Read data is visible in the data_ok cycle itself, then held by the
   // per-master capture register until that master's next completion.
   assign inst.rdata = (fin && (owner == OWN_INST)) ? mem.rdata : inst_rdata_q;
   assign data.rdata = (fin && (owner == OWN_DATA)) ? mem.rdata : data_rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         owner        <= OWN_DATA;
         inst_rdata_q <= {DW{1'b0}};
         data_rdata_q <= {DW{1'b0}};
`ifdef SRAM_ARB_RR_EN
         last_grant   <= OWN_DATA;
`else
         starve_cnt   <= {CW{1'b0}};
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner <= pick;
                  state <= ADDR;
`ifdef SRAM_ARB_RR_EN
                  last_grant <= pick;
`else
                  if ((pick == OWN_DATA) && inst.req) begin
                     if (starve_cnt != CW'(STARVE_LIMIT)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end else begin
                     starve_cnt <= {CW{1'b0}};
                  end
`endif
               end
            end
            ADDR: begin
               // Owner withdrawing before acceptance is an abort: no handshake.
               if (!own_req) begin
                  state <= IDLE;
               end else if (mem.addr_ok) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (mem.data_ok) begin
                  state <= IDLE;
                  if (owner == OWN_INST) begin
                     inst_rdata_q <= mem.rdata;
                  end else begin
                     data_rdata_q <= mem.rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
`timescale 1ns/1ps
module tb_sram_like_arbiter;
   import sram_arb_pkg::*;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   n_cmp = 0;
   int   n_bad = 0;

   sram_like_arbiter_if #(.AW(AW), .DW(DW)) inst_if (), data_if (), mem_if ();

   sram_like_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
      .clk  (clk),
      .rst  (rst),
      .inst (inst_if),
      .data (data_if),
      .mem  (mem_if),
      .busy (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   // Reference model: who gets the port and what each master last read.
   int          streak;      // data grants since inst was last served or idle
   bit          last_inst;   // previous grant went to inst
   logic [31:0] exp_irdata;
   logic [31:0] exp_drdata;

   function automatic bit model_grant(input bit ip, input bit dp);
      bit g;
      if (ip && !dp)      g = 1'b1;
      else if (!ip)       g = 1'b0;
      else begin
`ifdef SRAM_ARB_RR_EN
         g = !last_inst;
`else
         g = (LIM != 0) && (streak == LIM);
`endif
      end
      last_inst = g;
      if (!g && ip) streak = (streak < LIM) ? streak + 1 : LIM;
      else          streak = 0;
      return g;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Entered at pos+1 of an IDLE cycle with the requests already driven;
   // returns at pos+1 of the following IDLE cycle.
   task automatic do_xact(input int da, input int dd, output bit got_inst);
      bit          gi;
      logic [31:0] a, wd, rd;
      logic        w;
      logic [1:0]  s;
      got_inst = 1'b0;
      gi = model_grant(inst_if.req, data_if.req);
      a  = gi ? inst_if.addr  : data_if.addr;
      wd = gi ? inst_if.wdata : data_if.wdata;
      w  = gi ? inst_if.wr    : data_if.wr;
      s  = gi ? inst_if.size  : data_if.size;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_mem_req", mem_if.req, 0);
      for (int i = 0; i <= da; i++) begin
         nxt();
         mem_if.addr_ok = (i == da);
         mem_if.data_ok = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("addr_busy", busy, 1);
         chk("addr_mem_req", mem_if.req, 1);
         chk("addr_mem_addr", mem_if.addr, a);
         chk("addr_mem_wdata", mem_if.wdata, wd);
         chk("addr_mem_wr", mem_if.wr, w);
         chk("addr_mem_size", mem_if.size, s);
         chk("addr_inst_addr_ok", inst_if.addr_ok, gi && (i == da));
         chk("addr_data_addr_ok", data_if.addr_ok, !gi && (i == da));
         chk("addr_inst_data_ok", inst_if.data_ok, 0);
         chk("addr_data_data_ok", data_if.data_ok, 0);
         if (i == da) got_inst = inst_if.addr_ok;
      end
      nxt();
      mem_if.addr_ok = 1'b0;
      if (gi) inst_if.req = 1'b0;
      else    data_if.req = 1'b0;
      for (int i = 0; i <= dd; i++) begin
         if (i > 0) nxt();
         rd = $urandom;
         mem_if.data_ok = (i == dd);
         mem_if.rdata   = rd;
         mem_if.addr_ok = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("data_busy", busy, 1);
         chk("data_mem_req", mem_if.req, 0);
         chk("data_inst_addr_ok", inst_if.addr_ok, 0);
         chk("data_data_addr_ok", data_if.addr_ok, 0);
         chk("data_inst_data_ok", inst_if.data_ok, gi && (i == dd));
         chk("data_data_data_ok", data_if.data_ok, !gi && (i == dd));
         if (i == dd) begin
            if (gi) exp_irdata = rd;
            else    exp_drdata = rd;
         end
         chk("data_inst_rdata", inst_if.rdata, exp_irdata);
         chk("data_data_rdata", data_if.rdata, exp_drdata);
      end
      nxt();
      mem_if.data_ok = 1'b0;
      mem_if.addr_ok = 1'b0;
   endtask

   task automatic set_inst(input logic [31:0] a);
      inst_if.req = 1'b1; inst_if.wr = 1'b0; inst_if.size = SZ_WORD;
      inst_if.addr = a; inst_if.wdata = $urandom;
   endtask

   task automatic set_data(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] wd);
      data_if.req = 1'b1; data_if.wr = w; data_if.size = s;
      data_if.addr = a; data_if.wdata = wd;
   endtask

   initial begin
      bit got, g, exp_g;
      rst = 1'b1;
      inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0; inst_if.wdata = 0;
      data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wdata = 0;
      mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;
      streak = 0; last_inst = 1'b0; exp_irdata = '0; exp_drdata = '0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_if.req, 0);
      chk("rst_mem_addr", mem_if.addr, 0);
      chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
      chk("rst_data_data_ok", data_if.data_ok, 0);
      chk("rst_inst_rdata", inst_if.rdata, 0);
      chk("rst_data_rdata", data_if.rdata, 0);
      nxt();
      rst = 1'b0;

      // both masters held, memory always ready
      for (int i = 0; i < 10; i++) begin
         set_inst(32'hBFC0_0000 + 32'(i * 4));
         set_data(32'h8000_0000 + 32'(i * 4), 1'b0, SZ_WORD, 32'h0);
`ifdef SRAM_ARB_RR_EN
         exp_g = ((i % 2) == 0);
`else
         exp_g = ((i % 5) == 4);
`endif
         do_xact(0, 0, got);
         chk("t2_grant_seq", got, exp_g);
      end
      data_if.req = 1'b0; inst_if.req = 1'b0;
      nxt();

      // single inst read
      set_inst(32'hBFC0_0000);
      mem_if.addr_ok = 1'b1;
      g = model_grant(1'b1, 1'b0);
      @(negedge clk);
      chk("t1_c0_busy", busy, 0);
      chk("t1_c0_mem_req", mem_if.req, 0);
      chk("t1_c0_inst_addr_ok", inst_if.addr_ok, 0);
      nxt();
      @(negedge clk);
      chk("t1_c1_mem_req", mem_if.req, 1);
      chk("t1_c1_mem_addr", mem_if.addr, 32'hBFC0_0000);
      chk("t1_c1_inst_addr_ok", inst_if.addr_ok, g);
      chk("t1_c1_busy", busy, 1);
      chk("t1_c1_data_addr_ok", data_if.addr_ok, 0);
      nxt();
      inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      mem_if.data_ok = 1'b1; mem_if.rdata = 32'h3C1D_0000;
      @(negedge clk);
      chk("t1_c2_inst_data_ok", inst_if.data_ok, 1);
      chk("t1_c2_inst_rdata", inst_if.rdata, 32'h3C1D_0000);
      chk("t1_c2_busy", busy, 1);
      chk("t1_c2_mem_req", mem_if.req, 0);
      chk("t1_c2_data_data_ok", data_if.data_ok, 0);
      exp_irdata = 32'h3C1D_0000;
      nxt();
      mem_if.data_ok = 1'b0;
      @(negedge clk);
      chk("t1_c3_busy", busy, 0);
      chk("t1_c3_inst_data_ok", inst_if.data_ok, 0);
      chk("t1_c3_inst_rdata_hold", inst_if.rdata, 32'h3C1D_0000);
      nxt();

      // data write with 5 stall cycles on the address phase
      set_data(32'h8000_1000, 1'b1, SZ_WORD, 32'hDEAD_BEEF);
      do_xact(5, 1, got);
      chk("t3_owner_inst", got, 0);

      // spurious handshakes while idle
      mem_if.data_ok = 1'b1; mem_if.addr_ok = 1'b1; mem_if.rdata = 32'h1234_5678;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t6_busy", busy, 0);
         chk("t6_mem_req", mem_if.req, 0);
         chk("t6_inst_data_ok", inst_if.data_ok, 0);
         chk("t6_data_data_ok", data_if.data_ok, 0);
         chk("t6_inst_addr_ok", inst_if.addr_ok, 0);
         chk("t6_inst_rdata", inst_if.rdata, exp_irdata);
         chk("t6_data_rdata", data_if.rdata, exp_drdata);
         nxt();
      end
      mem_if.data_ok = 1'b0; mem_if.addr_ok = 1'b0;

      // inst abort in ADDR, pending data goes next
      set_inst(32'h0000_0100);
      g = model_grant(1'b1, 1'b0);
      @(negedge clk);
      chk("t4_idle_busy", busy, 0);
      nxt();
      set_data(32'h0000_2000, 1'b0, SZ_HALF, 32'h0);
      @(negedge clk);
      chk("t4_addr_mem_req", mem_if.req, 1);
      chk("t4_addr_mem_addr", mem_if.addr, 32'h0000_0100);
      chk("t4_addr_inst_addr_ok", inst_if.addr_ok, 0);
      nxt();
      inst_if.req = 1'b0; mem_if.addr_ok = 1'b1;
      @(negedge clk);
      chk("t4_abort_mem_req", mem_if.req, 0);
      chk("t4_abort_inst_addr_ok", inst_if.addr_ok, 0);
      chk("t4_abort_data_addr_ok", data_if.addr_ok, 0);
      nxt();
      mem_if.addr_ok = 1'b0;
      do_xact(0, 0, got);
      chk("t4_next_owner_inst", got, 0);

      // async reset in the data phase
      set_data(32'h0000_3000, 1'b0, SZ_BYTE, 32'h0);
      g = model_grant(1'b0, 1'b1);
      @(negedge clk);
      nxt();
      mem_if.addr_ok = 1'b1;
      @(negedge clk);
      chk("t5_data_addr_ok", data_if.addr_ok, 1);
      nxt();
      data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      @(negedge clk);
      chk("t5_data_busy", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_mem_req", mem_if.req, 0);
      chk("t5_rst_mem_addr", mem_if.addr, 0);
      chk("t5_rst_inst_rdata", inst_if.rdata, 0);
      chk("t5_rst_data_rdata", data_if.rdata, 0);
      mem_if.data_ok = 1'b1; mem_if.rdata = 32'hCAFE_F00D;
      #1;
      chk("t5_rst_data_data_ok", data_if.data_ok, 0);
      chk("t5_rst_inst_data_ok", inst_if.data_ok, 0);
      nxt();
      nxt();
      rst = 1'b0;
      streak = 0; last_inst = 1'b0; exp_irdata = '0; exp_drdata = '0;
      @(negedge clk);
      chk("t5_stray_data_data_ok", data_if.data_ok, 0);
      chk("t5_stray_inst_data_ok", inst_if.data_ok, 0);
      chk("t5_stray_data_rdata", data_if.rdata, 0);
      chk("t5_stray_busy", busy, 0);
      nxt();
      mem_if.data_ok = 1'b0;

      // randomized traffic against the model
      for (int k = 0; k < 150; k++) begin
         if (!inst_if.req && ($urandom_range(0, 1) != 0)) begin
            inst_if.req = 1'b1; inst_if.wr = 1'b0;
            inst_if.size = 2'($urandom_range(0, 2));
            inst_if.addr = $urandom; inst_if.wdata = $urandom;
         end
         if (!data_if.req && ($urandom_range(0, 2) != 0)) begin
            set_data($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom);
         end
         if (!inst_if.req && !data_if.req) begin
            set_data($urandom, 1'($urandom_range(0, 1)), SZ_WORD, $urandom);
         end
         do_xact($urandom_range(0, 3), $urandom_range(0, 3), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
